// File: rtl/sync_event_arbiter.sv
// Async-input event controller: per-channel two-flop synchronizer and debouncer, with
// round-robin queuing of debounced level changes onto one valid/ready record stream.

module sync2ps (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

module sync_event_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         async_in,
  input  logic [N-1:0]         en,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [$clog2(N)-1:0] ev_chan,
  output logic                 ev_rise,
  output logic [N-1:0]         level,
  output logic [N-1:0]         overflow,
  input  logic [N-1:0]         ovf_clr
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] CntLast = DW'(DEBOUNCE - 1);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StHold  = 1'b1;

  logic [N-1:0]    s;
  logic [DW-1:0]   cnt_q [N];
  logic [DW-1:0]   cnt_d [N];
  logic [N-1:0]    level_q, level_d;
  logic [N-1:0]    toggle;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    dir_q, dir_d;
  logic [N-1:0]    ovf_q, ovf_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic            rise_q, rise_d;
  logic            found;
  logic [CW-1:0]   pick;
  logic            load;
  logic            take;

  for (genvar i = 0; i < N; i++) begin : g_sync
    sync2ps u_sync (
      .clk (clk),
      .rst (rst),
      .d   (async_in[i]),
      .q   (s[i])
    );
  end

  // Debounce: a new synchronized value must persist DEBOUNCE cycles before level follows.
  always_comb begin
    level_d = level_q;
    toggle  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          level_d[i] = ~level_q[i];
          toggle[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = ptr_q;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end

  assign load = (state_q == StEmpty) || ev_ready;
  assign take = load && found;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    rise_d  = rise_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (found) begin
        state_d = StHold;
        chan_d  = pick;
        rise_d  = dir_q[pick];
        ptr_d   = pick;
      end else begin
        state_d = StEmpty;
      end
    end
  end

  // A change arriving while the slot is being drained refills it instead of overflowing.
  always_comb begin
    logic taken;
    pend_d = pend_q;
    dir_d  = dir_q;
    ovf_d  = ovf_q & ~ovf_clr;
    for (int i = 0; i < N; i++) begin
      taken = take && (pick == CW'(i));
      if (taken) begin
        pend_d[i] = 1'b0;
      end
      if (toggle[i] && en[i]) begin
        if (!pend_q[i] || taken) begin
          pend_d[i] = 1'b1;
          dir_d[i]  = level_d[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
      pend_q  <= '0;
      dir_q   <= '0;
      ovf_q   <= '0;
      ptr_q   <= CW'(N - 1);
      state_q <= StEmpty;
      chan_q  <= '0;
      rise_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      state_q <= state_d;
      chan_q  <= chan_d;
      rise_q  <= rise_d;
    end
  end

  assign ev_valid = (state_q == StHold);
  assign ev_chan  = chan_q;
  assign ev_rise  = rise_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Bench for sync_event_arbiter: directed scenarios plus random traffic, every cycle compared
// against a history-window / per-channel-slot reference model.

module tb_sync_event_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 3;
  localparam int unsigned CW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  async_in = '0;
  logic [N-1:0]  en = '1;
  logic          ev_ready = 1'b1;
  logic [N-1:0]  ovf_clr = '0;
  logic          ev_valid;
  logic [CW-1:0] ev_chan;
  logic          ev_rise;
  logic [N-1:0]  level;
  logic [N-1:0]  overflow;

  sync_event_arbiter #(
    .N        (N),
    .DEBOUNCE (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .async_in (async_in),
    .en       (en),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_chan  (ev_chan),
    .ev_rise  (ev_rise),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned hs_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: raw pins pass a two-stage delay; a level flips once the last D
  // synchronized samples all disagree with it; each channel owns a one-deep event slot.
  logic [N-1:0] m_sy1, m_s, m_level, m_pend, m_dir, m_ovf;
  logic [D-1:0] m_hist [N];
  int           m_ptr;
  bit           m_valid;
  int           m_chan;
  bit           m_rise;

  task automatic model_step();
    int           pick;
    bit           load_ok;
    bit           set_ovf;
    logic [N-1:0] pend_n, dir_n, ovf_n, lvl_n;
    if (rst) begin
      m_sy1 = '0; m_s = '0; m_level = '0; m_pend = '0; m_dir = '0; m_ovf = '0;
      for (int i = 0; i < N; i++) m_hist[i] = '0;
      m_ptr = N - 1; m_valid = 0; m_chan = 0; m_rise = 0;
      return;
    end
    load_ok = !m_valid || ev_ready;
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (pick < 0 && m_pend[idx]) pick = idx;
    end
    pend_n = m_pend; dir_n = m_dir; lvl_n = m_level; ovf_n = m_ovf;
    if (load_ok) begin
      if (pick >= 0) begin
        m_valid = 1; m_chan = pick; m_rise = m_dir[pick]; pend_n[pick] = 1'b0; m_ptr = pick;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      set_ovf = 0;
      m_hist[i] = {m_hist[i][D-2:0], m_s[i]};
      if (m_hist[i] == {D{~m_level[i]}}) begin
        lvl_n[i] = ~m_level[i];
        if (en[i]) begin
          if (!m_pend[i] || (load_ok && pick == i)) begin
            pend_n[i] = 1'b1;
            dir_n[i]  = lvl_n[i];
          end else begin
            set_ovf = 1;
          end
        end
      end
      if (set_ovf)         ovf_n[i] = 1'b1;
      else if (ovf_clr[i]) ovf_n[i] = 1'b0;
    end
    m_level = lvl_n; m_pend = pend_n; m_dir = dir_n; m_ovf = ovf_n;
    m_s = m_sy1;
    m_sy1 = async_in;
  endtask

  task automatic compare_all();
    check_eq("ev_valid", ev_valid, m_valid);
    if (m_valid) begin
      check_eq("ev_chan", ev_chan, m_chan);
      check_eq("ev_rise", ev_rise, m_rise);
    end
    check_eq("level", level, m_level);
    check_eq("overflow", overflow, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (ev_valid === 1'b1 && ev_ready) hs_seen++;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ovf", overflow, 0);

    // Single rising event and its latency.
    async_in[2] = 1'b1;
    tick();
    lat = 0;
    while (ev_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("latency", lat, 5);
    check_eq("first_chan", ev_chan, 2);
    check_eq("first_rise", ev_rise, 1);
    check_eq("first_level", level, 4'b0100);
    tick();
    check_eq("one_cycle", ev_valid, 0);
    async_in[2] = 1'b0;
    ticks(10);

    // Glitch rejection, then a just-long-enough pulse.
    hs_seen = 0;
    async_in[1] = 1'b1; ticks(2); async_in[1] = 1'b0; ticks(10);
    check_eq("glitch_events", hs_seen, 0);
    check_eq("glitch_level", level, 0);
    async_in[1] = 1'b1; ticks(3); async_in[1] = 1'b0; ticks(12);
    check_eq("pulse_events", hs_seen, 2);

    // Round robin, rising then falling.
    async_in = 4'hF; ticks(12);
    async_in = 4'h0; ticks(12);

    // Backpressure and overflow.
    ev_ready = 1'b0;
    async_in[0] = 1'b1; ticks(8);
    async_in[3] = 1'b1; ticks(4);
    async_in[3] = 1'b0; ticks(4);
    async_in[3] = 1'b1; ticks(8);
    check_eq("ovf_set", overflow[3], 1);
    check_eq("held_chan", ev_chan, 0);
    ev_ready = 1'b1; ticks(4);
    ovf_clr[3] = 1'b1; tick(); ovf_clr = '0;
    check_eq("ovf_clr", overflow[3], 0);
    async_in = '0; ticks(10);

    // Enable masking.
    en[1] = 1'b0; async_in[1] = 1'b1; ticks(8);
    en[1] = 1'b1; ticks(8);
    async_in[1] = 1'b0; ticks(8);

    // Reset while holding a record with two channels pending.
    ev_ready = 1'b0;
    async_in = 4'b0111; ticks(8);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("midrst_valid", ev_valid, 0);
    check_eq("midrst_level", level, 0);
    ev_ready = 1'b1; ticks(12);
    async_in = '0; ticks(10);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 4) == 0) async_in[i] = ~async_in[i];
        ovf_clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 29) == 0) en[$urandom_range(0, N - 1)] ^= 1'b1;
      if ((c / 150) % 2 == 0) ev_ready = ($urandom_range(0, 3) != 0);
      else                    ev_ready = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_event_arbiter.md
# sync_event_arbiter

Multi-channel input event controller. It synchronizes N asynchronous inputs, debounces each one, and turns every debounced level change into an event record. A round-robin arbiter queues those events onto a single valid/ready output for the bridge control logic. It sits at the asynchronous-input boundary: each channel uses one `sync2ps` instance, and nothing else in the design may sample those raw pins.

## Interface
- `N`, 4: number of input channels, range 2–16.
- `DEBOUNCE`, 3: number of consecutive synchronized cycles a new value must hold before it is accepted. Must be ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `async_in`  in  N  raw asynchronous inputs.
- `en`  in  N  per-channel event enable.
- `ev_valid`  out  1  event record valid.
- `ev_ready`  in  1  consumer accepts the record.
- `ev_chan`  out  $clog2(N)  channel index of the record.
- `ev_rise`  out  1  1 = rising change, 0 = falling change.
- `level`  out  N  debounced levels.
- `overflow`  out  N  sticky flag: an event was dropped on this channel.
- `ovf_clr`  in  N  per-channel overflow clear.

## Operation
- **Per channel i:** `sync2ps(clk, rst, async_in[i])` produces `s[i]`.
- **Debounce counter `cnt[i]`:** width $clog2(DEBOUNCE+1).
  - If `s[i]==level[i]`, `cnt <= 0`.
  - Otherwise, if `cnt==DEBOUNCE-1`, `level[i]` toggles and `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
  - A glitch shorter than DEBOUNCE synchronized cycles never changes `level`.
- **Change registration:** a toggle with `en[i]=1` produces a change.
  - If `pend[i]=0`: `pend[i] <= 1` and `dir[i] <= new level`.
  - If `pend[i]=1` and channel i is not being loaded this cycle: the new change is dropped, `dir[i]` is kept, and `overflow[i] <= 1`.
  - A toggle with `en[i]=0` updates `level` only.
  - Deasserting `en` does not clear an existing `pend`.
- **Output register load:** the register may load when `ev_valid==0` or `ev_valid&&ev_ready`.
  - The arbiter picks the first pending channel searching from `ptr+1` upward, modulo N.
  - On a pick it loads `ev_chan`/`ev_rise`, sets `ev_valid`, clears that channel's `pend`, and sets `ptr` to the picked channel.
  - If a handshake completes and nothing is pending, `ev_valid <= 0`.
- **Simultaneous load and new change, same channel:** the old record loads and `pend` is re-set with the new direction. No overflow.
- **Overflow clear:** `ovf_clr[i]` clears `overflow[i]`. A set in the same cycle wins.
- **States:** per channel IDLE (`pend=0`) / PENDING (`pend=1`); output EMPTY / HOLD. HOLD→HOLD while `!ev_ready`; HOLD→EMPTY on handshake with no pending; HOLD→HOLD with a new record on handshake with a pending channel.

## Timing
- **Reset values:**
  - `level`=0, `cnt`=0, `pend`=0, `dir`=0, `overflow`=0.
  - `ev_valid`=0, `ev_chan`=0, `ev_rise`=0.
  - `ptr`=N-1, so channel 0 wins first.
  - The synchronizers also reset.
- **Latency:** `async_in` changes and is first sampled at edge 0.
  - `s` changes at edge 1.
  - `level` toggles and `pend` sets at edge 1+DEBOUNCE.
  - `ev_valid` rises at edge 2+DEBOUNCE (5 cycles for DEBOUNCE=3) if the output was EMPTY.
- **Throughput:** with `ev_ready` held high, one record per cycle.
- **Output stability:** `ev_chan`/`ev_rise` must stay stable while `ev_valid && !ev_ready`.
- **Reset mid-operation:** all pending and in-flight records are discarded. An input held high through reset yields a rising event DEBOUNCE+2 cycles after the first non-reset edge.
- **Combinational paths:** none from `async_in` to any output. `ev_ready` affects state only at the clock edge.

## Test plan
- **Single rising event:** reset, N=4, DEBOUNCE=3, `en`=4'hF, `ev_ready`=1; raise `async_in[2]` → `ev_valid` high exactly 5 cycles later for 1 cycle with `ev_chan`=2, `ev_rise`=1; `level`=4'b0100.
- **Glitch rejection:** a 2-cycle pulse on `async_in[1]` → no event, `level` unchanged. A 3-cycle pulse → rise event then fall event on channel 1.
- **Round-robin fairness:** all 4 inputs rise in the same cycle, `ev_ready`=1 → records for channels 0,1,2,3 on consecutive cycles. Repeat with falling edges starting at `ptr`=3 → order 0,1,2,3.
- **Backpressure and overflow:** `ev_ready`=0; channel 0 rises and is loaded, then channel 3 rises, falls and rises (each held 4 cycles) → the output holds ch0 unchanged; `pend[3]` keeps the rise and `overflow[3]`=1. Set `ev_ready`=1 → ch0 then ch3-rise. Pulse `ovf_clr[3]` → `overflow[3]`=0.
- **Enable masking:** `en[1]`=0 and channel 1 rises → `level[1]`=1 with no event; set `en[1]`=1 → still no event until the next change.
- **Reset mid-operation:** assert `rst` for 1 cycle while `ev_valid`=1 and two channels are pending → all outputs return to reset values next cycle. Inputs still high → rise events DEBOUNCE+2 cycles after reset release, channel 0 first.
